// File: rtl/axi4_burst_beat_gen.sv
`default_nettype none
// =============================================================================
// Module  : axi4_burst_beat_gen
// Brief   : Expands one AXI4 AW/AR burst command into per-beat address,
//           byte strobe, beat index, last flag and OKAY/SLVERR response.
// Revision: 1.0
// =============================================================================
module axi4_burst_beat_gen #(
   parameter  int ADDRESS_WIDTH = 16,
   parameter  int DATA_WIDTH    = 32,
   parameter  int ID_WIDTH      = 8,
   parameter  int LENGTH        = 8,
   localparam int STROBE_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [ID_WIDTH-1:0]      cmd_id,
   input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
   input  logic [LENGTH-1:0]        cmd_len,
   input  logic [2:0]               cmd_size,
   input  logic [1:0]               cmd_burst,
   output logic                     beat_valid,
   input  logic                     beat_ready,
   output logic [ID_WIDTH-1:0]      beat_id,
   output logic [ADDRESS_WIDTH-1:0] beat_addr,
   output logic [STROBE_WIDTH-1:0]  beat_strb,
   output logic [LENGTH-1:0]        beat_idx,
   output logic                     beat_last,
   output logic [1:0]               beat_resp,
   output logic                     busy
);

   localparam int c_AW1 = ADDRESS_WIDTH + 1;
   localparam int c_KW  = LENGTH + 14;
   localparam logic [2:0] c_SIZE_MAX = 3'($clog2(STROBE_WIDTH));
   localparam logic [ADDRESS_WIDTH-1:0] c_LANE_MASK = ADDRESS_WIDTH'(STROBE_WIDTH - 1);

   localparam logic [0:0] c_IDLE  = 1'b0;
   localparam logic [0:0] c_BURST = 1'b1;

   localparam logic [1:0] c_FIXED  = 2'b00;
   localparam logic [1:0] c_INCR   = 2'b01;
   localparam logic [1:0] c_WRAP   = 2'b10;
   localparam logic [1:0] c_RSVD   = 2'b11;
   localparam logic [1:0] c_OKAY   = 2'b00;
   localparam logic [1:0] c_SLVERR = 2'b10;

   // Lanes from the (possibly unaligned) address up to the end of its aligned beat.
   function automatic logic [STROBE_WIDTH-1:0] f_strb(input logic [ADDRESS_WIDTH-1:0] addr,
                                                      input logic [2:0]               size);
      logic [ADDRESS_WIDTH-1:0] w_bytes_m1;
      logic [ADDRESS_WIDTH-1:0] w_lo;
      logic [ADDRESS_WIDTH-1:0] w_hi;
      w_bytes_m1 = (ADDRESS_WIDTH'(1) << size) - ADDRESS_WIDTH'(1);
      w_lo       = addr & c_LANE_MASK;
      w_hi       = (addr & ~w_bytes_m1 & c_LANE_MASK) + w_bytes_m1;
      for (int i = 0; i < STROBE_WIDTH; i++) begin
         f_strb[i] = (ADDRESS_WIDTH'(i) >= w_lo) && (ADDRESS_WIDTH'(i) <= w_hi);
      end
   endfunction

   logic [0:0]               r_state;
   logic [0:0]               w_state_next;
   logic                     w_cmd_ready;
   logic                     w_busy;
   logic                     w_accept;
   logic                     w_beat_hs;

   logic                     r_beat_valid;
   logic [ID_WIDTH-1:0]      r_beat_id;
   logic [ADDRESS_WIDTH-1:0] r_beat_addr;
   logic [STROBE_WIDTH-1:0]  r_beat_strb;
   logic [LENGTH-1:0]        r_beat_idx;
   logic                     r_beat_last;
   logic [1:0]               r_beat_resp;

   logic [LENGTH-1:0]        r_len;
   logic [2:0]               r_size;
   logic [1:0]               r_burst;
   logic                     r_err;
   logic [c_AW1-1:0]         r_lower;
   logic [c_AW1-1:0]         r_total;

   // ---------------------------------------------------------------- legality
   logic [c_AW1-1:0] w_cmd_ext;
   logic [c_AW1-1:0] w_cmd_bytes;
   logic [c_AW1-1:0] w_cmd_aligned;
   logic [c_AW1-1:0] w_cmd_total;
   logic [c_AW1-1:0] w_cmd_lower;
   logic [c_KW-1:0]  w_span;
   logic [c_KW-1:0]  w_4k_sum;
   logic             w_size_bad;
   logic             w_wrap_len_bad;
   logic             w_wrap_align_bad;
   logic             w_cross_4k;
   logic             w_cmd_err;

   assign w_cmd_ext        = {1'b0, cmd_addr};
   assign w_cmd_bytes      = c_AW1'(1) << cmd_size;
   assign w_cmd_aligned    = w_cmd_ext & ~(w_cmd_bytes - c_AW1'(1));
   assign w_cmd_total      = (c_AW1'(cmd_len) + c_AW1'(1)) << cmd_size;
   assign w_cmd_lower      = w_cmd_ext & ~(w_cmd_total - c_AW1'(1));
   assign w_span           = (c_KW'(cmd_len) + c_KW'(1)) << cmd_size;
   assign w_4k_sum         = c_KW'(w_cmd_aligned[11:0]) + w_span;
   assign w_cross_4k       = w_4k_sum > c_KW'(4096);
   assign w_size_bad       = cmd_size > c_SIZE_MAX;
   assign w_wrap_len_bad   = !((cmd_len == LENGTH'(1)) || (cmd_len == LENGTH'(3)) ||
                               (cmd_len == LENGTH'(7)) || (cmd_len == LENGTH'(15)));
   assign w_wrap_align_bad = (w_cmd_ext & (w_cmd_bytes - c_AW1'(1))) != '0;
   assign w_cmd_err        = (cmd_burst == c_RSVD) || w_size_bad ||
                             ((cmd_burst == c_WRAP) && (w_wrap_len_bad || w_wrap_align_bad)) ||
                             ((cmd_burst == c_INCR) && w_cross_4k);

   // ------------------------------------------------------- next beat address
   logic [c_AW1-1:0]         w_cur_ext;
   logic [c_AW1-1:0]         w_bytes;
   logic [c_AW1-1:0]         w_incr_next;
   logic [c_AW1-1:0]         w_wrap_inc;
   logic [c_AW1-1:0]         w_next_ext;
   logic [ADDRESS_WIDTH-1:0] w_next;
   logic [LENGTH-1:0]        w_idx_next;
   logic                     w_unused;

   assign w_cur_ext   = {1'b0, r_beat_addr};
   assign w_bytes     = c_AW1'(1) << r_size;
   assign w_incr_next = (w_cur_ext & ~(w_bytes - c_AW1'(1))) + w_bytes;
   assign w_wrap_inc  = w_cur_ext + w_bytes;
   assign w_idx_next  = r_beat_idx + LENGTH'(1);

   always_comb begin
      w_next_ext = w_cur_ext;
      if (!r_err) begin
         case (r_burst)
            c_INCR:  w_next_ext = w_incr_next;
            c_WRAP:  w_next_ext = (w_wrap_inc == (r_lower + r_total)) ? r_lower : w_wrap_inc;
            default: w_next_ext = w_cur_ext;
         endcase
      end
   end

   assign w_next   = w_next_ext[ADDRESS_WIDTH-1:0];
   assign w_unused = ^{w_cmd_aligned[ADDRESS_WIDTH:12], w_next_ext[ADDRESS_WIDTH]};

   // ---------------------------------------------------------------------- FSM
   assign w_accept  = cmd_valid && w_cmd_ready;
   assign w_beat_hs = r_beat_valid && beat_ready;

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE:  if (w_accept) w_state_next = c_BURST;
         c_BURST: if (w_beat_hs && r_beat_last) w_state_next = c_IDLE;
         default: w_state_next = c_IDLE;
      endcase
   end

   always_comb begin
      w_cmd_ready = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         c_IDLE:  w_cmd_ready = !areset;
         c_BURST: w_busy      = 1'b1;
         default: w_busy      = 1'b0;
      endcase
   end

   // ----------------------------------------------------------- beat datapath
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_beat_valid <= 1'b0;
         r_beat_id    <= '0;
         r_beat_addr  <= '0;
         r_beat_strb  <= '0;
         r_beat_idx   <= '0;
         r_beat_last  <= 1'b0;
         r_beat_resp  <= c_OKAY;
         r_len        <= '0;
         r_size       <= '0;
         r_burst      <= c_FIXED;
         r_err        <= 1'b0;
         r_lower      <= '0;
         r_total      <= '0;
      end else if (w_accept) begin
         r_beat_valid <= 1'b1;
         r_beat_id    <= cmd_id;
         r_beat_addr  <= cmd_addr;
         r_beat_strb  <= w_cmd_err ? '0 : f_strb(cmd_addr, cmd_size);
         r_beat_idx   <= '0;
         r_beat_last  <= (cmd_len == '0);
         r_beat_resp  <= w_cmd_err ? c_SLVERR : c_OKAY;
         r_len        <= cmd_len;
         r_size       <= cmd_size;
         r_burst      <= cmd_burst;
         r_err        <= w_cmd_err;
         r_lower      <= w_cmd_lower;
         r_total      <= w_cmd_total;
      end else if (w_beat_hs) begin
         if (r_beat_last) begin
            r_beat_valid <= 1'b0;
         end else begin
            r_beat_idx  <= w_idx_next;
            r_beat_last <= (w_idx_next == r_len);
            r_beat_addr <= w_next;
            r_beat_strb <= r_err ? '0 : f_strb(w_next, r_size);
         end
      end
   end

   assign cmd_ready  = w_cmd_ready;
   assign busy       = w_busy;
   assign beat_valid = r_beat_valid;
   assign beat_id    = r_beat_id;
   assign beat_addr  = r_beat_addr;
   assign beat_strb  = r_beat_strb;
   assign beat_idx   = r_beat_idx;
   assign beat_last  = r_beat_last;
   assign beat_resp  = r_beat_resp;

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_beat_gen.sv
`default_nettype none
// =============================================================================
// Module  : tb_axi4_burst_beat_gen
// Brief   : Directed bursts checked every cycle against a beat-list model.
// Revision: 1.0
// =============================================================================
module tb_axi4_burst_beat_gen;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int IW = 8;
   localparam int LW = 8;
   localparam int SW = DW / 8;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [IW-1:0] cmd_id = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic [2:0]    cmd_size = '0;
   logic [1:0]    cmd_burst = '0;
   logic          beat_valid;
   logic          beat_ready = 1'b1;
   logic [IW-1:0] beat_id;
   logic [AW-1:0] beat_addr;
   logic [SW-1:0] beat_strb;
   logic [LW-1:0] beat_idx;
   logic          beat_last;
   logic [1:0]    beat_resp;
   logic          busy;

   always #5 aclk = ~aclk;

   axi4_burst_beat_gen #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LENGTH(LW)) u_dut (
      .aclk(aclk), .areset(areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
      .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id),
      .beat_addr(beat_addr), .beat_strb(beat_strb), .beat_idx(beat_idx),
      .beat_last(beat_last), .beat_resp(beat_resp), .busy(busy)
   );

   typedef struct packed {
      logic [IW-1:0] id;
      logic [AW-1:0] addr;
      logic [SW-1:0] strb;
      logic [LW-1:0] idx;
      logic          last;
      logic [1:0]    resp;
   } beat_t;

   beat_t         exp_q[$];
   logic          exp_busy = 1'b0;
   logic          prev_valid = 1'b0;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;
   int            log_n = 0;
   logic [AW-1:0] log_addr[16];
   logic [SW-1:0] log_strb[16];
   logic [1:0]    log_resp[16];
   logic [IW-1:0] log_id[16];
   logic          log_last[16];
   int            dut_start[$];
   int            dut_end[$];

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [SW-1:0] lanes(input int a, input int bytes);
      int lo;
      int hi;
      lo    = a % SW;
      hi    = (a & ~(bytes - 1)) % SW + bytes - 1;
      lanes = '0;
      for (int i = 0; i < SW; i++) if (i >= lo && i <= hi) lanes[i] = 1'b1;
   endfunction

   // Beat list straight from the burst rules, with plain integer arithmetic.
   function automatic void model_push(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                      input logic [LW-1:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
      int    bytes, total, aligned, lower, a, n_beats;
      bit    err;
      beat_t b;
      bytes   = 1 << size;
      n_beats = int'(len) + 1;
      total   = bytes * n_beats;
      aligned = int'(addr) & ~(bytes - 1);
      lower   = int'(addr) & ~(total - 1);
      err     = (burst == 2'b11) || (bytes > SW) ||
                (burst == 2'b10 && !(len inside {1, 3, 7, 15})) ||
                (burst == 2'b10 && (int'(addr) % bytes) != 0) ||
                (burst == 2'b01 && ((aligned & 'hFFF) + n_beats * bytes > 4096));
      a = int'(addr);
      for (int n = 0; n < n_beats; n++) begin
         if (n > 0 && !err) begin
            if (burst == 2'b01) a = aligned + n * bytes;
            else if (burst == 2'b10) begin
               a = a + bytes;
               if (a == lower + total) a = lower;
            end
         end
         b.id   = id;
         b.addr = a[AW-1:0];
         b.strb = err ? '0 : lanes(a, bytes);
         b.idx  = n[LW-1:0];
         b.last = (n == n_beats - 1);
         b.resp = err ? 2'b10 : 2'b00;
         exp_q.push_back(b);
      end
   endfunction

   always @(negedge aclk) begin
      check("cmd_ready", cmd_ready, !exp_busy && !areset);
      check("beat_valid", beat_valid, exp_busy);
      check("busy", busy, exp_busy);
      if (exp_busy && exp_q.size() > 0) begin
         check("beat_id", beat_id, exp_q[0].id);
         check("beat_addr", beat_addr, exp_q[0].addr);
         check("beat_strb", beat_strb, exp_q[0].strb);
         check("beat_idx", beat_idx, exp_q[0].idx);
         check("beat_last", beat_last, exp_q[0].last);
         check("beat_resp", beat_resp, exp_q[0].resp);
      end
      if (!areset) begin
         if (beat_valid && !prev_valid) dut_start.push_back(cyc);
         if (beat_valid && beat_ready) begin
            if (beat_last) dut_end.push_back(cyc);
            if (log_n < 16) begin
               log_addr[log_n] = beat_addr;
               log_strb[log_n] = beat_strb;
               log_resp[log_n] = beat_resp;
               log_id[log_n]   = beat_id;
               log_last[log_n] = beat_last;
               log_n++;
            end
         end
      end
      prev_valid = beat_valid && !areset;
      if (areset) exp_busy = 1'b0;
      else if (!exp_busy) exp_busy = cmd_valid;
      else if (beat_ready && exp_q.size() > 0) begin
         if (exp_q[0].last) exp_busy = 1'b0;
         void'(exp_q.pop_front());
      end
   end

   task automatic wait_accept();
      bit done = 0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge aclk);
         if (cmd_ready) begin
            @(posedge aclk); #1;
            done = 1;
         end
      end
      if (!done) check("accept_timeout", 0, 1);
   endtask

   task automatic send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
      model_push(id, addr, len, size, burst);
      cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
      cmd_valid = 1'b1;
      wait_accept();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit done = 0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(posedge aclk); #1;
         done = (exp_q.size() == 0) && !exp_busy;
      end
      if (!done) begin
         check("burst_timeout", 0, 1);
         exp_q.delete();
      end
   endtask

   task automatic wait_idx(input int k);
      bit done = 0;
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge aclk);
         done = beat_valid && (int'(beat_idx) == k);
      end
      if (!done) check("idx_timeout", 0, 1);
   endtask

   task automatic check_log(input int i, input logic [AW-1:0] a, input logic [SW-1:0] s,
                            input logic [1:0] r);
      check($sformatf("log_addr[%0d]", i), log_addr[i], a);
      check($sformatf("log_strb[%0d]", i), log_strb[i], s);
      check($sformatf("log_resp[%0d]", i), log_resp[i], r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge aclk);
      #1;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_beat_valid", beat_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_beat_addr", beat_addr, 0);
      check("rst_beat_idx", beat_idx, 0);
      areset = 1'b0;
      @(negedge aclk);
      check("release_cmd_ready", cmd_ready, 1);
      @(posedge aclk); #1;

      // INCR unaligned start
      log_n = 0;
      send(8'h11, 16'h0102, 8'd3, 3'd2, 2'b01);
      wait_done();
      check("incr_beats", log_n, 4);
      check_log(0, 16'h0102, 4'b1100, 2'b00);
      check_log(1, 16'h0104, 4'b1111, 2'b00);
      check_log(2, 16'h0108, 4'b1111, 2'b00);
      check_log(3, 16'h010C, 4'b1111, 2'b00);
      check("incr_last3", log_last[3], 1);
      check("incr_last2", log_last[2], 0);

      // WRAP
      log_n = 0;
      send(8'h22, 16'h0038, 8'd3, 3'd2, 2'b10);
      wait_done();
      check("wrap_beats", log_n, 4);
      check_log(0, 16'h0038, 4'b1111, 2'b00);
      check_log(1, 16'h003C, 4'b1111, 2'b00);
      check_log(2, 16'h0030, 4'b1111, 2'b00);
      check_log(3, 16'h0034, 4'b1111, 2'b00);

      // FIXED byte burst
      log_n = 0;
      send(8'h33, 16'h0041, 8'd2, 3'd0, 2'b00);
      wait_done();
      check("fixed_beats", log_n, 3);
      for (int i = 0; i < 3; i++) check_log(i, 16'h0041, 4'b0010, 2'b00);

      // Illegal: INCR crossing 4 KB
      log_n = 0;
      send(8'h44, 16'h0FF8, 8'd3, 3'd2, 2'b01);
      wait_done();
      check("x4k_beats", log_n, 4);
      for (int i = 0; i < 4; i++) check_log(i, 16'h0FF8, 4'b0000, 2'b10);

      // Illegal: oversize transfer
      log_n = 0;
      send(8'h55, 16'h0200, 8'd1, 3'd3, 2'b01);
      wait_done();
      check("oversize_beats", log_n, 2);
      for (int i = 0; i < 2; i++) check_log(i, 16'h0200, 4'b0000, 2'b10);

      // Illegal: WRAP length 3 beats
      log_n = 0;
      send(8'h66, 16'h0040, 8'd2, 3'd2, 2'b10);
      wait_done();
      check("wraplen_beats", log_n, 3);
      for (int i = 0; i < 3; i++) check_log(i, 16'h0040, 4'b0000, 2'b10);

      // Illegal: reserved burst type
      log_n = 0;
      send(8'h67, 16'h0010, 8'd0, 3'd2, 2'b11);
      wait_done();
      check("rsvd_beats", log_n, 1);
      check_log(0, 16'h0010, 4'b0000, 2'b10);

      // Backpressure: stall 3 cycles while beat 2 is presented
      log_n = 0;
      send(8'h77, 16'h0200, 8'd7, 3'd2, 2'b01);
      wait_idx(1);
      @(posedge aclk); #1;
      beat_ready = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      beat_ready = 1'b1;
      wait_done();
      check("stall_beats", log_n, 8);
      check_log(2, 16'h0208, 4'b1111, 2'b00);
      check_log(7, 16'h021C, 4'b1111, 2'b00);

      // Single-beat burst
      log_n = 0;
      send(8'h88, 16'h0500, 8'd0, 3'd2, 2'b01);
      wait_done();
      check("len0_beats", log_n, 1);
      check("len0_last", log_last[0], 1);

      // Reset mid-burst
      send(8'h99, 16'h0300, 8'd7, 3'd2, 2'b01);
      wait_idx(3);
      @(posedge aclk); #1;
      areset = 1'b1;
      @(posedge aclk); #1;
      check("midrst_beat_valid", beat_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_cmd_ready", cmd_ready, 0);
      check("midrst_beat_addr", beat_addr, 0);
      check("midrst_beat_strb", beat_strb, 0);
      check("midrst_beat_id", beat_id, 0);
      check("midrst_beat_last", beat_last, 0);
      exp_q.delete();
      areset = 1'b0;
      @(negedge aclk);
      check("midrst_release_ready", cmd_ready, 1);
      @(posedge aclk); #1;

      // Back-to-back commands with cmd_valid held
      log_n = 0;
      dut_start.delete();
      dut_end.delete();
      model_push(8'h05, 16'h0400, 8'd1, 3'd2, 2'b01);
      model_push(8'h0A, 16'h0600, 8'd1, 3'd2, 2'b01);
      cmd_id = 8'h05; cmd_addr = 16'h0400; cmd_len = 8'd1; cmd_size = 3'd2; cmd_burst = 2'b01;
      cmd_valid = 1'b1;
      wait_accept();
      cmd_id = 8'h0A; cmd_addr = 16'h0600;
      wait_accept();
      cmd_valid = 1'b0;
      wait_done();
      check("b2b_beats", log_n, 4);
      check("b2b_id0", log_id[0], 8'h05);
      check("b2b_id1", log_id[1], 8'h05);
      check("b2b_id2", log_id[2], 8'h0A);
      check("b2b_id3", log_id[3], 8'h0A);
      check_log(2, 16'h0600, 4'b1111, 2'b00);
      check("b2b_starts", dut_start.size(), 2);
      check("b2b_ends", dut_end.size(), 2);
      if (dut_start.size() >= 2 && dut_end.size() >= 1)
         check("b2b_gap", dut_start[1] - dut_end[0], 2);

      repeat (3) @(posedge aclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
